assoc_icache: RTL

Parametrised set-associative instruction cache that replaces the direct-mapped single-word icache between the datapath fetch stage and the memory controller. It has a configurable set count and associativity, with round-robin replacement. It latches the miss address so the fill completes correctly even if the fetch address moves. It adds a whole-cache flush and saturating hit/miss performance counters. One instance sits per CPU; the iREN/iaddr/iwait/iload ports connect to that CPU's slot of the controller.

---
 rtl/assoc_icache.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/assoc_icache.sv
// Set-associative instruction cache with round-robin replacement,
// whole-cache flush and saturating hit/miss counters.
module assoc_icache #(
  parameter int SETS  = 16,
  parameter int WAYS  = 2,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             imemREN,
  input  logic [31:0]      imemaddr,
  input  logic             pcRST,
  input  logic             flush,
  output logic             ihit,
  output logic [31:0]      imemload,
  output logic             iREN,
  output logic [31:0]      iaddr,
  input  logic             iwait,
  input  logic [31:0]      iload,
  output logic [CNT_W-1:0] hit_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 30 - IW;
  localparam int RW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] READM = 1'b1;

  logic [0:0]      state;
  logic [31:0]     missAddr;
  logic [WAYS-1:0] valid [SETS];
  logic [TW-1:0]   tags  [SETS][WAYS];
  logic [31:0]     data  [SETS][WAYS];

  logic [IW-1:0] idx;
  logic [IW-1:0] missIdx;
  logic [TW-1:0] tag;
  logic [TW-1:0] missTag;

  assign idx     = imemaddr[2+IW-1:2];
  assign tag     = imemaddr[31:2+IW];
  assign missIdx = missAddr[2+IW-1:2];
  assign missTag = missAddr[31:2+IW];

  logic [WAYS-1:0] hitWay;
  logic [31:0]     hitData;
  logic            anyHit;

  always_comb begin
    hitWay  = '0;
    hitData = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[idx][w] && tags[idx][w] == tag) begin
        hitWay[w] = 1'b1;
        hitData   = hitData | data[idx][w];
      end
    end
  end

  assign anyHit   = |hitWay;
  assign ihit     = anyHit & imemREN & ~pcRST & (state == IDLE);
  assign imemload = ihit ? hitData : '0;
  assign iREN     = (state == READM);
  assign iaddr    = iREN ? {missAddr[31:2], 2'b00} : '0;

  logic missStart;
  logic fillEn;

  assign missStart = (state == IDLE) & imemREN & ~pcRST & ~anyHit & ~flush;
  assign fillEn    = (state == READM) & ~flush & ~pcRST & ~iwait;

  logic [RW-1:0] victim;
  logic [RW-1:0] rrCur;
  logic          freeFound;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    victim    = rrCur;
    freeFound = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[missIdx][w]) begin
        victim    = RW'(w);
        freeFound = 1'b1;
      end
    end
  end

  generate
    if (WAYS > 1) begin : g_rr
      logic [RW-1:0] rr [SETS];
      assign rrCur = rr[missIdx];
      always_ff @(posedge CLK) begin
        if (!nRST || flush) begin
          for (int s = 0; s < SETS; s++) rr[s] <= '0;
        end else if (fillEn && !freeFound) begin
          rr[missIdx] <= victim + RW'(1);
        end
      end
    end else begin : g_norr
      assign rrCur = '0;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      missAddr   <= '0;
      hit_count  <= '0;
      miss_count <= '0;
      for (int s = 0; s < SETS; s++) valid[s] <= '0;
    end else begin
      if (ihit && hit_count != '1)
        hit_count <= hit_count + CNT_W'(1);
      if (missStart && miss_count != '1)
        miss_count <= miss_count + CNT_W'(1);
      if (flush) begin
        state <= IDLE;
        for (int s = 0; s < SETS; s++) valid[s] <= '0;
      end else begin
        unique case (1'b1)
          (state == IDLE): begin
            if (missStart) begin
              missAddr <= imemaddr;
              state    <= READM;
            end
          end
          (state == READM): begin
            if (pcRST || !iwait) state <= IDLE;
            if (fillEn) valid[missIdx][victim] <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Tag/data arrays carry no reset; valid bits gate their use.
  always_ff @(posedge CLK) begin
    if (fillEn) begin
      tags[missIdx][victim] <= missTag;
      data[missIdx][victim] <= iload;
    end
  end

endmodule
